// File: rtl/sd_block_arbiter.sv
// rtl/sd_block_arbiter.sv - round-robin N-channel SD block request arbiter
// Latches per-channel read/write pulses and runs the sd_rd/sd_wr/sd_ack handshake one channel at a time.
module sd_block_arbiter #(
  parameter int          NCH     = 3,
  parameter int          LBA_W   = 32,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_rd,
  input  logic [NCH-1:0]       req_wr,
  input  logic [NCH*LBA_W-1:0] req_lba,
  input  logic [NCH-1:0]       mounted,
  output logic [NCH*LBA_W-1:0] sd_lba,
  output logic [NCH-1:0]       sd_rd,
  output logic [NCH-1:0]       sd_wr,
  input  logic [NCH-1:0]       sd_ack,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       err,
  output logic [2:0]           active_ch
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t           state;
  logic [NCH-1:0]   pend_rd, pend_wr, ack_q;
  logic [LBA_W-1:0] lat_lba [NCH];
  logic [2:0]       rr_ptr;
  logic [23:0]      timer;
  logic             op_rd;

  logic [NCH-1:0] set_rd, set_wr, act_oh, gnt_oh, clr_rd, clr_wr, hold;
  logic [7:0]     pend_pad, rd_pad, ack_pad, ackq_pad;
  logic           gnt_ok, ack_rise, ack_fall, tmo, finish;
  logic [2:0]     gnt_ch, nxt_ptr;
  logic [3:0]     idx;

  for (genvar i = 0; i < NCH; i++) begin : g_lba
    assign sd_lba[i*LBA_W +: LBA_W] = lat_lba[i];
  end

  always_comb begin
    set_rd   = req_rd & mounted;
    set_wr   = req_wr & mounted;
    pend_pad = 8'(pend_rd | pend_wr);
    rd_pad   = 8'(pend_rd);
    ack_pad  = 8'(sd_ack);
    ackq_pad = 8'(ack_q);
    act_oh   = NCH'(8'd1 << active_ch);
    // First pending channel at or above rr_ptr, wrapping at NCH.
    gnt_ok = 1'b0;
    gnt_ch = 3'd0;
    idx    = 4'd0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
      if (!gnt_ok && pend_pad[idx[2:0]]) begin
        gnt_ok = 1'b1;
        gnt_ch = idx[2:0];
      end
    end
    gnt_oh   = NCH'(8'd1 << gnt_ch);
    ack_rise = ack_pad[active_ch] & ~ackq_pad[active_ch];
    ack_fall = ~ack_pad[active_ch] & ackq_pad[active_ch];
    tmo      = (TIMEOUT != 24'd0) && (timer == TIMEOUT - 24'd1);
    finish   = (state == REQ && tmo && !ack_rise) || (state == XFER && (ack_fall || tmo));
    clr_rd   = '0;
    clr_wr   = '0;
    if (state == REQ && (ack_rise || tmo)) begin
      if (op_rd) clr_rd = act_oh;
      else       clr_wr = act_oh;
    end
    hold    = (state != IDLE && !finish) ? act_oh : '0;
    nxt_ptr = (active_ch == 3'(NCH-1)) ? 3'd0 : active_ch + 3'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      pend_rd   <= '0;
      pend_wr   <= '0;
      ack_q     <= '0;
      rr_ptr    <= 3'd0;
      timer     <= 24'd0;
      op_rd     <= 1'b0;
      active_ch <= 3'd0;
      sd_rd     <= '0;
      sd_wr     <= '0;
      busy      <= '0;
      done      <= '0;
      err       <= '0;
      for (int i = 0; i < NCH; i++) lat_lba[i] <= '0;
    end else begin
      ack_q   <= sd_ack;
      done    <= '0;
      err     <= '0;
      // Set wins over the clear of the op being retired.
      pend_rd <= (pend_rd & ~clr_rd) | set_rd;
      pend_wr <= (pend_wr & ~clr_wr) | set_wr;
      busy    <= set_rd | set_wr | (pend_rd & ~clr_rd) | (pend_wr & ~clr_wr) | hold;
      for (int i = 0; i < NCH; i++)
        if (set_rd[i] | set_wr[i]) lat_lba[i] <= req_lba[i*LBA_W +: LBA_W];
      case (state)
        IDLE: if (gnt_ok) begin
          active_ch <= gnt_ch;
          op_rd     <= rd_pad[gnt_ch];
          if (rd_pad[gnt_ch]) sd_rd <= gnt_oh;
          else                sd_wr <= gnt_oh;
          timer <= 24'd0;
          state <= REQ;
        end
        REQ: if (ack_rise) begin
          sd_rd <= '0;
          sd_wr <= '0;
          timer <= 24'd0;
          state <= XFER;
        end else if (tmo) begin
          sd_rd  <= '0;
          sd_wr  <= '0;
          err    <= act_oh;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end else if (timer != '1) begin
          timer <= timer + 24'd1;
        end
        XFER: if (ack_fall) begin
          done   <= act_oh;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end else if (tmo) begin
          err    <= act_oh;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end else if (timer != '1) begin
          timer <= timer + 24'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb/tb_sd_block_arbiter.sv - directed self-checking bench for sd_block_arbiter
`timescale 1ns/1ps
module tb_sd_block_arbiter;
  localparam int NCH = 3;
  localparam int LW  = 32;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic [NCH-1:0]    req_rd = '0, req_wr = '0, mounted = '1, sd_ack = '0, sd_ack_t = '0;
  logic [NCH*LW-1:0] req_lba = '0, sd_lba, sd_lba_t;
  logic [NCH-1:0]    sd_rd, sd_wr, busy, done, err;
  logic [NCH-1:0]    sd_rd_t, sd_wr_t, busy_t, done_t, err_t;
  logic [2:0]        active_ch, active_ch_t;
  int compared = 0, mismatched = 0, multi = 0;

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] lba;
    bit          mnt;
    int          dly;
    int          len;
    bit          go;
  } vec_t;
  vec_t vt[6];

  always #5 clk_sys = ~clk_sys;

  sd_block_arbiter #(.NCH(NCH), .LBA_W(LW), .TIMEOUT(24'd1000)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .mounted(mounted), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .busy(busy), .done(done), .err(err), .active_ch(active_ch));

  sd_block_arbiter #(.NCH(NCH), .LBA_W(LW), .TIMEOUT(24'd16)) dut_t (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .mounted(mounted), .sd_lba(sd_lba_t), .sd_rd(sd_rd_t), .sd_wr(sd_wr_t), .sd_ack(sd_ack_t),
    .busy(busy_t), .done(done_t), .err(err_t), .active_ch(active_ch_t));

  always @(negedge clk_sys)
    if (!reset && ($countones(sd_rd | sd_wr) > 1 || $countones(sd_rd_t | sd_wr_t) > 1)) multi++;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int ch);
    return 3'(1 << ch);
  endfunction

  task automatic serve(input int ch, input bit wr, input bit busy_after, input string nm);
    int n;
    n = 0;
    while ((sd_rd | sd_wr) == '0 && n < 20) begin
      tick;
      n++;
    end
    chk({nm, "_rd"}, 32'(sd_rd), wr ? 32'd0 : 32'(oh(ch)));
    chk({nm, "_wr"}, 32'(sd_wr), wr ? 32'(oh(ch)) : 32'd0);
    chk({nm, "_ch"}, 32'(active_ch), 32'(ch));
    sd_ack[ch] = 1'b1;
    tick;
    chk({nm, "_strobe_off"}, 32'(sd_rd | sd_wr), 32'd0);
    tick;
    sd_ack[ch] = 1'b0;
    tick;
    chk({nm, "_done"}, 32'(done), 32'(oh(ch)));
    chk({nm, "_busy"}, 32'(busy[ch]), 32'(busy_after));
    chk({nm, "_idle_gap"}, 32'(sd_rd | sd_wr), 32'd0);
  endtask

  initial begin
    int n, bad, dseen;
    vt[0] = '{ch:0, wr:1'b0, lba:32'h0000_1234, mnt:1'b1, dly:5, len:512, go:1'b1};
    vt[1] = '{ch:1, wr:1'b1, lba:32'hDEAD_BEEF, mnt:1'b1, dly:0, len:3,   go:1'b1};
    vt[2] = '{ch:2, wr:1'b0, lba:32'h0000_0001, mnt:1'b1, dly:2, len:1,   go:1'b1};
    vt[3] = '{ch:2, wr:1'b1, lba:32'h0000_ABCD, mnt:1'b0, dly:0, len:1,   go:1'b0};
    vt[4] = '{ch:2, wr:1'b1, lba:32'hFFFF_FFFF, mnt:1'b1, dly:1, len:4,   go:1'b1};
    vt[5] = '{ch:1, wr:1'b0, lba:32'h5555_0000, mnt:1'b0, dly:0, len:1,   go:1'b0};

    repeat (3) tick;
    chk("rst_strobe", 32'(sd_rd | sd_wr), 32'd0);
    chk("rst_busy", 32'(busy | done | err), 32'd0);
    chk("rst_ch", 32'(active_ch), 32'd0);
    chk("rst_lba", 32'(sd_lba == '0), 32'd1);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) begin
      req_lba[vt[i].ch*LW +: LW] = vt[i].lba;
      mounted[vt[i].ch] = vt[i].mnt;
      if (vt[i].wr) req_wr[vt[i].ch] = 1'b1;
      else          req_rd[vt[i].ch] = 1'b1;
      tick;
      req_rd = '0;
      req_wr = '0;
      chk($sformatf("v%0d_busy_rise", i), 32'(busy), vt[i].go ? 32'(oh(vt[i].ch)) : 32'd0);
      tick;
      chk($sformatf("v%0d_rd", i), 32'(sd_rd), (vt[i].go && !vt[i].wr) ? 32'(oh(vt[i].ch)) : 32'd0);
      chk($sformatf("v%0d_wr", i), 32'(sd_wr), (vt[i].go && vt[i].wr) ? 32'(oh(vt[i].ch)) : 32'd0);
      if (vt[i].go) begin
        chk($sformatf("v%0d_lba", i), sd_lba[vt[i].ch*LW +: LW], vt[i].lba);
        chk($sformatf("v%0d_ch", i), 32'(active_ch), 32'(vt[i].ch));
        bad = 0;
        repeat (vt[i].dly) begin
          tick;
          if ((sd_rd | sd_wr) != oh(vt[i].ch)) bad++;
        end
        chk($sformatf("v%0d_strobe_hold", i), 32'(bad), 32'd0);
        sd_ack[vt[i].ch] = 1'b1;
        tick;
        chk($sformatf("v%0d_strobe_off", i), 32'(sd_rd | sd_wr), 32'd0);
        chk($sformatf("v%0d_busy_xfer", i), 32'(busy), 32'(oh(vt[i].ch)));
        repeat (vt[i].len - 1) tick;
        chk($sformatf("v%0d_no_early_done", i), 32'(done), 32'd0);
        sd_ack[vt[i].ch] = 1'b0;
        tick;
        chk($sformatf("v%0d_done", i), 32'(done), 32'(oh(vt[i].ch)));
        chk($sformatf("v%0d_busy_fall", i), 32'(busy), 32'd0);
        tick;
        chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      end else begin
        bad = 0;
        repeat (8) begin
          tick;
          if ((sd_rd | sd_wr | busy | done) != '0) bad++;
        end
        chk($sformatf("v%0d_dropped", i), 32'(bad), 32'd0);
      end
      mounted = '1;
    end

    req_rd = 3'b111;
    tick;
    req_rd = '0;
    serve(0, 1'b0, 1'b0, "rr_a0");
    serve(1, 1'b0, 1'b0, "rr_a1");
    serve(2, 1'b0, 1'b0, "rr_a2");
    req_rd = 3'b101;
    tick;
    req_rd = '0;
    serve(0, 1'b0, 1'b0, "rr_b0");
    serve(2, 1'b0, 1'b0, "rr_b2");

    req_rd = 3'b010;
    req_wr = 3'b010;
    tick;
    req_rd = '0;
    req_wr = '0;
    serve(1, 1'b0, 1'b1, "rw_rd");
    serve(1, 1'b1, 1'b0, "rw_wr");

    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    req_rd = 3'b011;
    tick;
    req_rd = '0;
    chk("to_busy", 32'(busy_t), 32'd3);
    tick;
    chk("to_grant0", 32'(sd_rd_t), 32'd1);
    n = 1;
    while (sd_rd_t[0] && n < 40) begin
      tick;
      if (sd_rd_t[0]) n++;
    end
    chk("to_width", 32'(n), 32'd16);
    chk("to_err", 32'(err_t), 32'd1);
    chk("to_no_done", 32'(done_t), 32'd0);
    chk("to_busy_clear", 32'(busy_t), 32'd2);
    tick;
    chk("to_err_pulse", 32'(err_t), 32'd0);
    chk("to_grant1", 32'(sd_rd_t), 32'd2);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_rd = 3'b100;
    tick;
    req_rd = '0;
    tick;
    chk("rx_strobe", 32'(sd_rd), 32'd4);
    sd_ack[2] = 1'b1;
    tick;
    chk("rx_xfer", 32'(sd_rd | busy), 32'd4);
    reset = 1'b1;
    tick;
    chk("rx_strobe_off", 32'(sd_rd | sd_wr), 32'd0);
    chk("rx_flags", 32'(busy | done | err), 32'd0);
    chk("rx_ch", 32'(active_ch), 32'd0);
    reset = 1'b0;
    sd_ack[2] = 1'b0;
    dseen = 0;
    repeat (4) begin
      tick;
      if ((done | busy | sd_rd | sd_wr) != '0) dseen++;
    end
    chk("rx_stale_ack", 32'(dseen), 32'd0);

    chk("one_strobe", 32'(multi), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Generalises the single-drive HDD read/write handshake into an N-channel SD block-request arbiter between the core's storage clients (HDD, floppy tracks, etc.) and the hps_io virtual-disk interface.
- Latches one-cycle read/write request pulses per channel and serves them one at a time, round-robin.
- Drives the sd_rd/sd_wr/sd_lba handshake and waits for sd_ack to rise, then fall.
- Gives each channel a busy flag (CPU wait), a done pulse and a timeout error pulse.

Parameters:
- NCH, 3: number of channels, 1..8.
- LBA_W, 32: LBA width per channel.
- TIMEOUT, 24'd2000000: clk_sys cycles allowed per handshake phase; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_rd  in  NCH  one-cycle read request pulse, per channel.
- req_wr  in  NCH  one-cycle write request pulse, per channel.
- req_lba  in  NCH*LBA_W  LBA, channel i at bits [i*LBA_W +: LBA_W]; sampled in the cycle a pulse arrives.
- mounted  in  NCH  image present; requests on unmounted channels are dropped.
- sd_lba  out  NCH*LBA_W  LBA presented to hps_io, same channel packing.
- sd_rd  out  NCH  read strobe to hps_io.
- sd_wr  out  NCH  write strobe to hps_io.
- sd_ack  in  NCH  acknowledge from hps_io.
- busy  out  NCH  channel has a pending or active operation.
- done  out  NCH  one-cycle pulse: operation completed.
- err  out  NCH  one-cycle pulse: operation timed out.
- active_ch  out  3  channel currently granted; valid while not IDLE.

Behaviour:
- Reset values: every output is 0. State is IDLE, pending flags are cleared, the round-robin pointer is 0, the timer is 0.
- Reset mid-transfer: sd_rd/sd_wr drop on the next edge, with no done or err pulse.
- Pending latch: when req_rd[i] & mounted[i], set pend_rd[i] and capture lat_lba[i] <= req_lba slice i. The same applies to req_wr into pend_wr[i].
- A new request that coincides with the pending-clear of the same type on the same channel stays set (set wins).
- Requests with mounted[i]=0 are ignored entirely: no busy, no done.
- busy[i] = pend_rd[i] | pend_wr[i] | (state != IDLE & active_ch == i), registered.
- busy rises the cycle after the request pulse.
- sd_lba slice i is always lat_lba[i].
- State machine:
  - IDLE: if any channel is pending, grant the first pending channel searching from rr_ptr upward with wrap.
    - Set active_ch, op = read if pend_rd, else write (read wins when both are pending; the write stays pending).
    - Assert sd_rd[ch] or sd_wr[ch], clear the timer, go to REQ.
    - A request arriving in IDLE is granted no earlier than the cycle after it is latched.
  - REQ: hold the strobe until sd_ack[ch] rises. The edge is detected from the registered previous ack.
    - On the rising edge: deassert the strobe, clear the pending bit for op, clear the timer, go to XFER.
  - XFER: wait for the falling edge of sd_ack[ch].
    - Then pulse done[ch], set rr_ptr = ch+1 mod NCH, go to IDLE.
    - busy[ch] falls in the same cycle done pulses, unless another op remains pending on that channel.
  - Timeout (TIMEOUT != 0): the timer increments in REQ and XFER. Reaching TIMEOUT-1 means:
    - deassert the strobe;
    - clear the pending bit for op;
    - pulse err[ch] instead of done;
    - advance rr_ptr;
    - go to IDLE.
  - sd_ack on non-active channels is ignored.
- Only one strobe bit across sd_rd|sd_wr is ever high.
- Channel switch spacing: at least one IDLE cycle between the end of one op and the next strobe.
- The timer saturates and never wraps.
- mounted[ch] dropping mid-operation does not abort; the operation completes or times out normally.

Test Plan:
- Single read ch0, LBA 0x1234:
  - Stimulus: pulse req_rd[0]; ack rises 5 cycles after sd_rd[0], falls after 512 cycles.
  - Required: sd_lba[0]=0x1234; sd_rd[0] high from cycle 2 until the ack rise; done[0] one cycle after the ack fall; busy[0] 1→0.
- Round-robin:
  - Stimulus: req_rd on ch0, ch1, ch2 in the same cycle.
  - Required: served in order 0,1,2; then a new ch0 and ch2 request with rr_ptr=0 serves 0 then 2. Never two strobes at once.
- Read+write same channel:
  - Stimulus: req_rd[1] and req_wr[1] together.
  - Required: the read completes first, then sd_wr[1] is issued; busy[1] stays high throughout; two done pulses.
- Timeout:
  - Stimulus: TIMEOUT=16, no ack.
  - Required: sd_rd drops after 16 cycles, err pulses once, done stays 0, busy clears, the next pending channel is granted.
- Unmounted drop:
  - Stimulus: req_wr[2] with mounted[2]=0.
  - Required: no strobe, busy[2] stays 0.
- Reset mid-XFER:
  - Stimulus: assert reset during XFER.
  - Required: all outputs 0 next cycle; the stale ack fall afterwards produces no done.
